// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment bit order, the legal hex glyphs and
// the all-off pattern. Used by both the display driver and the reader.
package sevenseg_pkg;

  // Bit positions inside a 7-bit segment word (active-low on the pins).
  typedef enum logic [2:0] {
    SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G
  } seg_idx_t;

  typedef enum logic [1:0] {
    CAP_NONE, CAP_LEGAL, CAP_BLANK, CAP_ILLEGAL
  } cap_kind_t;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  // Active-low glyph for a hex nibble, written g..a.
  function automatic logic [6:0] hex_pattern(input logic [3:0] n);
    logic [6:0] p;
    p = BLANK;
    case (n)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0011000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      4'hF: p = 7'b0001110;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational inverse of the glyph table: segment word to nibble, with flags
// for a legal hex glyph and for the all-off pattern.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == hex_pattern(4'(i))) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
    blank = (seg == BLANK);
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Snoops a multiplexed active-low 4-digit seven-segment bus and rebuilds the
// displayed hex value, with per-digit freshness, blank and bad-glyph flags.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_blank,
  output logic [3:0]  pattern_err,
  output logic        upd
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    SMAX  = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    an_m, an_s, an_p;
  logic [6:0]    seg_m, seg_s, seg_p;
  logic [7:0]    stab_cnt, stab_nxt;
  logic [TW-1:0] tcnt [NUM_DIGITS];
  logic [27:0]   out_q;
  logic          usable, capture;
  logic [1:0]    sel;
  cap_kind_t     kind;
  logic [3:0]    dec_nibble;
  logic          dec_legal, dec_blank;

  sevenseg_pattern_decode u_decode (
    .seg    (seg_s),
    .nibble (dec_nibble),
    .legal  (dec_legal),
    .blank  (dec_blank)
  );

  // Capture fires on the same edge the stability count reaches its limit, so a
  // pin change shows on the outputs STABLE_CYCLES+3 edges later.
  always_comb begin
    usable = ($countones(~an_s) == 1);
    sel    = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) sel = 2'(i);
    end
    stab_nxt = 8'd0;
    if (usable && (an_s == an_p) && (seg_s == seg_p))
      stab_nxt = (stab_cnt == SMAX) ? SMAX : stab_cnt + 8'd1;
    capture = usable && (stab_nxt == SMAX);
    kind    = CAP_NONE;
    if (capture) begin
      if (dec_legal)      kind = CAP_LEGAL;
      else if (dec_blank) kind = CAP_BLANK;
      else                kind = CAP_ILLEGAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_m        <= 4'h0;
      an_s        <= 4'h0;
      an_p        <= 4'h0;
      seg_m       <= 7'h0;
      seg_s       <= 7'h0;
      seg_p       <= 7'h0;
      stab_cnt    <= 8'd0;
      value       <= 16'h0;
      digit_valid <= 4'h0;
      digit_blank <= 4'h0;
      pattern_err <= 4'h0;
      out_q       <= 28'h0;
      upd         <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) tcnt[i] <= '0;
    end else begin
      an_m     <= an;
      an_s     <= an_m;
      seg_m    <= seg;
      seg_s    <= seg_m;
      an_p     <= an_s;
      seg_p    <= seg_s;
      stab_cnt <= stab_nxt;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && (sel == 2'(i))) begin
          tcnt[i] <= '0;
          case (kind)
            CAP_LEGAL: begin
              value[4*i +: 4] <= dec_nibble;
              digit_valid[i]  <= 1'b1;
              digit_blank[i]  <= 1'b0;
              pattern_err[i]  <= 1'b0;
            end
            CAP_BLANK: begin
              digit_valid[i]  <= 1'b0;
              digit_blank[i]  <= 1'b1;
              pattern_err[i]  <= 1'b0;
            end
            default: begin
              digit_valid[i]  <= 1'b0;
              digit_blank[i]  <= 1'b0;
              pattern_err[i]  <= 1'b1;
            end
          endcase
        end else begin
          // Stale digit: only the valid flag drops; the counter parks at the limit.
          if (tcnt[i] != TMAX) tcnt[i] <= tcnt[i] + TW'(1);
          if (tcnt[i] >= TLAST) digit_valid[i] <= 1'b0;
        end
      end
      out_q <= {value, digit_valid, digit_blank, pattern_err};
      upd   <= ({value, digit_valid, digit_blank, pattern_err} != out_q);
    end
  end

endmodule

// File: tb/tb_sevenseg_reader.sv
// Bench for sevenseg_reader: directed scenarios plus random bus traffic, all
// compared against a sample-window reference model of the reader.
module tb_sevenseg_reader;

  localparam int S = 4;
  localparam int T = 64;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an    = 4'hF;
  logic [6:0]  seg   = 7'h7F;
  logic [15:0] value;
  logic [3:0]  digit_valid, digit_blank, pattern_err;
  logic        upd;

  int n_tests = 0;
  int n_fail  = 0;

  sevenseg_reader #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .pattern_err (pattern_err),
    .upd         (upd)
  );

  always #5 clk = ~clk;

  logic [6:0] pat_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- reference model ----------------
  // A digit is captured at edge k when the pins driven before edges
  // k-2 .. k-2-S were identical with exactly one anode active.
  logic [10:0] hist [S+3];
  logic [15:0] m_value;
  logic [3:0]  m_valid, m_blank, m_err;
  logic        m_upd;
  logic [27:0] m_snap;
  int          edge_n;
  int          last_cap [4];
  logic [28:0] dut_vec, mdl_vec;

  assign dut_vec = {upd, value, digit_valid, digit_blank, pattern_err};
  assign mdl_vec = {m_upd, m_value, m_valid, m_blank, m_err};

  task automatic m_reset();
    for (int i = 0; i < S + 3; i++) hist[i] = '0;
    m_value = '0; m_valid = '0; m_blank = '0; m_err = '0;
    m_upd = 1'b0; m_snap = '0; edge_n = 0;
    for (int i = 0; i < 4; i++) last_cap[i] = 0;
  endtask

  task automatic m_edge();
    logic        stable;
    int          zeros, d, nib;
    logic        legal;
    logic [3:0]  a;
    logic [6:0]  s;
    edge_n++;
    for (int i = S + 2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {an, seg};
    m_upd  = ({m_value, m_valid, m_blank, m_err} != m_snap);
    m_snap = {m_value, m_valid, m_blank, m_err};
    stable = 1'b1;
    for (int j = 1; j <= S; j++) if (hist[2+j] != hist[2]) stable = 1'b0;
    a = hist[2][10:7];
    s = hist[2][6:0];
    zeros = 0; d = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; d = i; end
    legal = 1'b0; nib = 0;
    for (int n = 0; n < 16; n++) if (s == pat_tab[n]) begin legal = 1'b1; nib = n; end
    for (int i = 0; i < 4; i++) begin
      if (stable && zeros == 1 && d == i) begin
        last_cap[i] = edge_n;
        if (legal) begin
          m_value[4*i +: 4] = 4'(nib);
          m_valid[i] = 1'b1; m_blank[i] = 1'b0; m_err[i] = 1'b0;
        end else if (s == 7'h7F) begin
          m_valid[i] = 1'b0; m_blank[i] = 1'b1; m_err[i] = 1'b0;
        end else begin
          m_valid[i] = 1'b0; m_blank[i] = 1'b0; m_err[i] = 1'b1;
        end
      end else if (edge_n - last_cap[i] >= T) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else m_edge();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an = a; seg = s;
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; an = 4'hF; seg = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (value !== 16'h0) begin n_fail++; $display("FAIL reset_value: got %h expected 0000", value); end
    n_tests++;
    if (digit_valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", digit_valid); end
    n_tests++;
    if ({digit_blank, pattern_err} !== 8'h0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000000", {digit_blank, pattern_err}); end
    n_tests++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b expected 0", upd); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_digit();
    int cap_edge, upd_edge, upd_cnt;
    cap_edge = 0; upd_edge = 0; upd_cnt = 0;
    @(negedge clk);
    an = 4'b1110; seg = 7'b0100100;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (cap_edge == 0 && digit_valid == 4'b0001 && value[3:0] == 4'd2) cap_edge = e;
      if (upd) begin upd_cnt++; if (upd_edge == 0) upd_edge = e; end
      n_tests++;
      if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL single_model e=%0d: got %h expected %h", e, dut_vec, mdl_vec); end
    end
    n_tests++;
    if (cap_edge != S + 3) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", cap_edge, S + 3); end
    n_tests++;
    if (upd_edge != S + 4) begin n_fail++; $display("FAIL single_upd_edge: got %0d expected %0d", upd_edge, S + 4); end
    n_tests++;
    if (upd_cnt != 1) begin n_fail++; $display("FAIL single_upd_count: got %0d expected 1", upd_cnt); end
  endtask

  task automatic test_scan();
    logic [3:0] anv [4];
    int         nib [4];
    int         g, u_first, u_late;
    anv = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    nib = '{3, 10, 0, 15};
    g = 0; u_first = 0; u_late = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < 4; d++) begin
        @(negedge clk);
        an = anv[d]; seg = pat_tab[nib[d]];
        for (int c = 0; c < 6; c++) begin
          @(posedge clk); #1;
          g++;
          // Last first-pass capture lands on edge 25, its upd on edge 26.
          if (upd) begin if (g <= 26) u_first++; else u_late++; end
          n_tests++;
          if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL scan_model g=%0d: got %h expected %h", g, dut_vec, mdl_vec); end
        end
      end
    end
    hold(4'hF, 7'h7F, 4);
    #1;
    n_tests++;
    if (u_first != 4) begin n_fail++; $display("FAIL scan_upd_first: got %0d expected 4", u_first); end
    n_tests++;
    if (u_late != 0) begin n_fail++; $display("FAIL scan_upd_second: got %0d expected 0", u_late); end
    n_tests++;
    if (value !== 16'hF0A3) begin n_fail++; $display("FAIL scan_value: got %h expected F0A3", value); end
    n_tests++;
    if (digit_valid !== 4'hF) begin n_fail++; $display("FAIL scan_valid: got %b expected 1111", digit_valid); end
  endtask

  task automatic test_unstable();
    logic [27:0] snap;
    int          upd_seen;
    upd_seen = 0;
    snap = {value, digit_valid, digit_blank, pattern_err};
    @(negedge clk);
    an = 4'b0011; seg = pat_tab[8];
    for (int c = 0; c < 27; c++) begin
      @(posedge clk); #1;
      if (upd) upd_seen++;
      n_tests++;
      if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL unstable_model c=%0d: got %h expected %h", c, dut_vec, mdl_vec); end
      if (c >= 8 && (c - 8) % 3 == 0) begin
        @(negedge clk);
        an = 4'b1110;
        seg = (((c - 8) / 3) % 2 == 0) ? pat_tab[1] : pat_tab[8];
      end
    end
    n_tests++;
    if (upd_seen != 0) begin n_fail++; $display("FAIL unstable_upd: got %0d expected 0", upd_seen); end
    n_tests++;
    if ({value, digit_valid, digit_blank, pattern_err} !== snap) begin
      n_fail++; $display("FAIL unstable_hold: got %h expected %h", {value, digit_valid, digit_blank, pattern_err}, snap);
    end
  endtask

  task automatic test_blank_err();
    @(negedge clk);
    an = 4'b1101; seg = 7'b1111111;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL blank_model c=%0d: got %h expected %h", c, dut_vec, mdl_vec); end
    end
    n_tests++;
    if ({digit_blank[1], digit_valid[1], pattern_err[1]} !== 3'b100) begin
      n_fail++; $display("FAIL blank_flags: got %b expected 100", {digit_blank[1], digit_valid[1], pattern_err[1]});
    end
    n_tests++;
    if (value[7:4] !== 4'hA) begin n_fail++; $display("FAIL blank_nibble: got %h expected a", value[7:4]); end
    @(negedge clk);
    seg = 7'b0101010;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL err_model c=%0d: got %h expected %h", c, dut_vec, mdl_vec); end
    end
    n_tests++;
    if ({digit_blank[1], digit_valid[1], pattern_err[1]} !== 3'b001) begin
      n_fail++; $display("FAIL err_flags: got %b expected 001", {digit_blank[1], digit_valid[1], pattern_err[1]});
    end
    n_tests++;
    if (value[7:4] !== 4'hA) begin n_fail++; $display("FAIL err_nibble: got %h expected a", value[7:4]); end
  endtask

  task automatic test_timeout();
    int clr, u, drops;
    // Expiry: captures repeat through edge 8+2, so valid drops T+2 edges after idling.
    pulse_reset(2);
    hold(4'b1110, pat_tab[5], 8);
    @(negedge clk);
    an = 4'hF;
    clr = 0; u = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      if (upd) u++;
      n_tests++;
      if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL timeout_model j=%0d: got %h expected %h", j, dut_vec, mdl_vec); end
      if (!digit_valid[0]) begin clr = j; break; end
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (upd) u++;
    end
    n_tests++;
    if (clr != T + 2) begin n_fail++; $display("FAIL timeout_edge: got %0d expected %0d", clr, T + 2); end
    n_tests++;
    if (value[3:0] !== 4'h5) begin n_fail++; $display("FAIL timeout_value: got %h expected 5", value[3:0]); end
    n_tests++;
    if (u != 1) begin n_fail++; $display("FAIL timeout_upd: got %0d expected 1", u); end

    // Re-presented so the new capture lands exactly on the expiry edge (74).
    pulse_reset(2);
    drops = 0; u = 0;
    @(negedge clk);
    an = 4'b1110; seg = pat_tab[5];
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk); #1;
      if (e >= S + 3 && digit_valid[0] !== 1'b1) drops++;
      if (upd) u++;
      n_tests++;
      if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL expiry_model e=%0d: got %h expected %h", e, dut_vec, mdl_vec); end
      if (e == 8)  begin @(negedge clk); an = 4'hF; end
      if (e == 67) begin @(negedge clk); an = 4'b1110; end
    end
    n_tests++;
    if (drops != 0) begin n_fail++; $display("FAIL expiry_capture_wins: got %0d drops expected 0", drops); end
    n_tests++;
    if (u != 1) begin n_fail++; $display("FAIL expiry_upd: got %0d expected 1", u); end
  endtask

  task automatic test_reset_mid();
    int cap_edge;
    cap_edge = 0;
    @(negedge clk);
    an = 4'b1011; seg = pat_tab[7];
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({value, digit_valid, digit_blank, pattern_err, upd} !== 29'h0) begin
      n_fail++; $display("FAIL midreset_async: got %h expected 0", {value, digit_valid, digit_blank, pattern_err, upd});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (cap_edge == 0 && digit_valid[2]) cap_edge = e;
      n_tests++;
      if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL midreset_model e=%0d: got %h expected %h", e, dut_vec, mdl_vec); end
    end
    n_tests++;
    if (cap_edge != S + 3) begin n_fail++; $display("FAIL midreset_window: got %0d expected %0d", cap_edge, S + 3); end
    n_tests++;
    if (value[11:8] !== 4'h7) begin n_fail++; $display("FAIL midreset_value: got %h expected 7", value[11:8]); end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [6:0] s;
    int         r, n;
    pulse_reset(2);
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 8) a = 4'hF;
      else             a = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r < 6)       s = pat_tab[$urandom_range(0, 15)];
      else if (r == 6) s = 7'h7F;
      else             s = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 10);
      @(negedge clk);
      an = a; seg = s;
      for (int c = 0; c < n; c++) begin
        @(posedge clk); #1;
        n_tests++;
        if (dut_vec !== mdl_vec) begin n_fail++; $display("FAIL random_model k=%0d c=%0d: got %h expected %h", k, c, dut_vec, mdl_vec); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_scan();
    test_unstable();
    test_blank_err();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
